vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Parametrised VGA test-pattern generator, the successor to the switch-driven solid-colour test top. It sits between `vga_sync` (consumes `p_tick`, `video_on`, `x`, `y`) and the RGB DAC pins. It produces one of four selectable patterns: solid colour, colour bars, checkerboard, or an animated moving bar. Mode changes are frame-synchronous, so a switch never tears mid-frame.

## Interface
- `COLOR_W`, 12, total RGB width; must be a multiple of 3; channel width `C = COLOR_W/3`, packed {R,G,B}.
- `H_ACTIVE`, 640, visible pixels per line; must be divisible by 8.
- `V_ACTIVE`, 480, visible lines per frame.
- `BAR_H`, 16, moving-bar height in lines.
- `BAR_STEP`, 2, lines the bar advances per frame; must be < `V_ACTIVE`.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `p_tick` input 1: pixel-enable strobe from `vga_sync`.
- `video_on` input 1: active-area flag from `vga_sync`.
- `x` input 10: current pixel column.
- `y` input 10: current pixel row.
- `sw` input COLOR_W: user colour.
- `mode_sel` input 2: requested mode.
- `mode_load` input 1: one-clock request to adopt `mode_sel`.
- `rgb` output COLOR_W: registered pixel colour.
- `mode` output 2: currently active mode.
- `frame_tick` output 1: one-clock pulse at each frame boundary.

## Operation
- Modes:
  - 0 = solid `sw`.
  - 1 = eight vertical bars, each `H_ACTIVE/8` wide, left to right: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or all-zeros. Bar index comes from comparators against multiples of `H_ACTIVE/8`, not a divider.
  - 2 = 32x32 checkerboard: `sw` where `x[5]^y[5]==0`, else `~sw`.
  - 3 = moving bar: `sw` where `bar_y <= y < bar_y+BAR_H`, black elsewhere. The bar is clipped at the bottom edge; no wrapped drawing.
- Frame boundary: the cycle with `p_tick=1`, `x==0`, `y==V_ACTIVE`, which is the first pixel of vertical blank.
- Mode control:
  - `mode_load=1` latches `mode_sel` into a pending register and sets `pend_valid`.
  - At a frame boundary with `pend_valid=1`: `mode` <= pending, and `pend_valid` clears.
  - Multiple loads within one frame: the last one wins.
  - A load in the same cycle as a boundary bypasses the pending register and takes effect at that boundary.
- Bar position:
  - `bar_y` is 10 bits and advances at every frame boundary in all modes.
  - Update: `bar_y <= bar_y+BAR_STEP`; if the result is `>= V_ACTIVE`, it becomes `bar_y+BAR_STEP-V_ACTIVE` (modular wrap).
  - Mode 3 uses the `bar_y` in effect during the frame being drawn.
- Blanking: `rgb` is all-zero for any pixel sampled with `video_on=0`.
- Reset values: `rgb=0`, `mode=0`, `frame_tick=0`, `bar_y=0`, `pend_valid=0`, pending register 0.
- Reset mid-frame clears all state immediately. No pattern output appears until the first `p_tick` after reset deasserts.

## Timing
- Pixel pipeline latency is one `p_tick`. On a `p_tick` cycle, `rgb` registers the colour for the `x`, `y`, `video_on`, `sw`, `mode` values sampled in that cycle. `rgb` holds between ticks.
- `frame_tick` is high for exactly the one `clk` cycle following the boundary cycle, in the same cycle that `mode` and `bar_y` show their new values.
- Pixels sampled in the boundary cycle use the old `mode`/`bar_y`. These pixels are blanked anyway.
- `mode_load` is sampled on every `clk`, independent of `p_tick`.
- `x`/`y` values beyond the active area (blanking) are never decoded into colour.

## Configuration
- `VGA_PATTERN_BORDER_EN` defined: a 1-pixel full-white (all ones) border overrides every mode at `x==0`, `x==H_ACTIVE-1`, `y==0`, `y==V_ACTIVE-1`. Blanking still takes priority.
- Not defined: no border logic is compiled, and the pattern colour reaches the edges unchanged.

## Test plan
- Reset during active video with `sw=12'hF0A`, mode 0 → `rgb=0`, `mode=0`. After release, active pixels read `12'hF0A` one `p_tick` after sampling; blanked pixels read `12'h000`.
- `mode_sel=1`, `mode_load` pulsed mid-frame → `mode` stays 0 until the frame boundary, then 1 with `frame_tick` pulse. Next frame: `x=0`→`12'hFFF`, `x=80`→`12'hFF0`, `x=560`→`12'h000`.
- Two loads in one frame (mode 2, then 3) → `mode` becomes 3 at the boundary and never shows 2. A load coincident with the boundary takes effect in that same boundary.
- Mode 2 with `sw=12'h123` → (x=0,y=0)=`12'h123`, (32,0)=`12'hEDC`, (32,32)=`12'h123`.
- Mode 3, `BAR_STEP=2`, 240 frame boundaries from reset → `bar_y` wraps from 478 to 0. When `bar_y=470`, lines 470–479 show `sw`, and no bar pixels appear at y<470.
- With `VGA_PATTERN_BORDER_EN`, mode 0, `sw=12'h00F` → (0,100), (639,5), (300,479) = `12'hFFF`; (1,1)=`12'h00F`. Without the macro, all four pixels = `12'h00F`.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//
// VGA test-pattern generator that sits between vga_sync and the RGB DAC pins.
// It offers four patterns: solid colour, colour bars, checkerboard, and a
// bar that moves down the screen. A requested mode only takes effect at the
// next frame boundary, so a mode change never tears in the middle of a frame.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   p_tick     - pixel-enable strobe from vga_sync
//   video_on   - active-area flag from vga_sync
//   x, y       - current pixel column / row from vga_sync
//   sw         - user colour, packed {R,G,B}
//   mode_sel   - requested pattern mode
//   mode_load  - one-clock request to adopt mode_sel at the next frame boundary
//   rgb        - registered pixel colour (one p_tick of latency)
//   mode       - currently active pattern mode
//   frame_tick - one-clock pulse in the cycle after each frame boundary
//
// Optional feature:
//   VGA_PATTERN_BORDER_EN - when defined, a 1-pixel all-ones border overrides
//   every pattern on the outermost active rows and columns. Blanking still
//   takes priority over the border.
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
  parameter int COLOR_W  = 12,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BAR_H    = 16,
  parameter int BAR_STEP = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_tick,
  input  logic               video_on,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [COLOR_W-1:0] sw,
  input  logic [1:0]         mode_sel,
  input  logic               mode_load,
  output logic [COLOR_W-1:0] rgb,
  output logic [1:0]         mode,
  output logic               frame_tick
);

  localparam int C = COLOR_W / 3;

  localparam logic [9:0]  BAR_W   = 10'(H_ACTIVE / 8);
  localparam logic [9:0]  V_END   = 10'(V_ACTIVE);
  localparam logic [10:0] V_ACT11 = 11'(V_ACTIVE);
  localparam logic [10:0] STEP11  = 11'(BAR_STEP);
  localparam logic [10:0] BAR_H11 = 11'(BAR_H);

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_MOVING  = 2'd3
  } mode_t;

  mode_t                mode_q;
  mode_t                pend_mode;
  logic                 pend_valid;
  logic [9:0]           bar_y;
  logic [9:0]           bar_next;
  logic [10:0]          bar_sum;
  logic                 boundary;
  logic [2:0]           bar_idx;
  logic [2:0]           bar_bits;
  logic [COLOR_W-1:0]   bar_colour;
  logic                 in_bar;
  logic [COLOR_W-1:0]   pattern;
  logic [COLOR_W-1:0]   pixel;

  assign mode = mode_q;

  // The first pixel of vertical blank marks the frame boundary.
  assign boundary = p_tick && (x == 10'd0) && (y == V_END);

  // Next bar row with a modular wrap; done in 11 bits so the sum cannot
  // overflow before it is compared against the frame height.
  always_comb begin
    bar_sum  = {1'b0, bar_y} + STEP11;
    bar_next = bar_sum[9:0];
    if (bar_sum >= V_ACT11) begin
      bar_next = 10'(bar_sum - V_ACT11);
    end
  end

  // Bar index: count how many bar edges lie at or left of x. This compares
  // against fixed multiples of the bar width instead of dividing.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x >= 10'(k) * BAR_W) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
  end

  // Bar colours left to right as {R,G,B} on/off flags.
  always_comb begin
    bar_bits = 3'b000;
    case (bar_idx)
      3'd0:    bar_bits = 3'b111;
      3'd1:    bar_bits = 3'b110;
      3'd2:    bar_bits = 3'b011;
      3'd3:    bar_bits = 3'b010;
      3'd4:    bar_bits = 3'b101;
      3'd5:    bar_bits = 3'b100;
      3'd6:    bar_bits = 3'b001;
      default: bar_bits = 3'b000;
    endcase
    bar_colour = {{C{bar_bits[2]}}, {C{bar_bits[1]}}, {C{bar_bits[0]}}};
  end

  // The moving bar is clipped at the bottom edge: the upper bound is computed
  // in 11 bits so it never wraps back to the top of the screen.
  assign in_bar = ({1'b0, y} >= {1'b0, bar_y}) &&
                  ({1'b0, y} <  ({1'b0, bar_y} + BAR_H11));

  // Pattern selection for the currently active mode.
  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_SOLID:   pattern = sw;
      MODE_BARS:    pattern = bar_colour;
      MODE_CHECKER: pattern = (x[5] ^ y[5]) ? ~sw : sw;
      MODE_MOVING:  pattern = in_bar ? sw : '0;
      default:      pattern = '0;
    endcase
  end

  // Final pixel: blanking wins over everything, then the optional border,
  // then the selected pattern.
`ifdef VGA_PATTERN_BORDER_EN
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);
  logic on_border;
  assign on_border = (x == 10'd0) || (x == H_LAST) ||
                     (y == 10'd0) || (y == V_LAST);
  always_comb begin
    pixel = '0;
    if (video_on) begin
      pixel = on_border ? '1 : pattern;
    end
  end
`else
  always_comb begin
    pixel = '0;
    if (video_on) begin
      pixel = pattern;
    end
  end
`endif

  // Mode control, bar position, frame pulse and the pixel register.
  // A load in the boundary cycle skips the pending register and is adopted
  // immediately; later assignments win so repeated loads keep the latest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_SOLID;
      pend_mode  <= MODE_SOLID;
      pend_valid <= 1'b0;
      bar_y      <= '0;
      frame_tick <= 1'b0;
      rgb        <= '0;
    end else begin
      frame_tick <= boundary;
      if (mode_load) begin
        pend_mode  <= mode_t'(mode_sel);
        pend_valid <= 1'b1;
      end
      if (boundary) begin
        bar_y <= bar_next;
        if (mode_load) begin
          mode_q     <= mode_t'(mode_sel);
          pend_valid <= 1'b0;
        end else if (pend_valid) begin
          mode_q     <= pend_mode;
          pend_valid <= 1'b0;
        end
      end
      if (p_tick) begin
        rgb <= pixel;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen
//
// Self-checking bench for vga_pattern_gen with default parameters. Inputs are
// driven per clock; frame boundaries are produced by driving x=0, y=V_ACTIVE
// with p_tick, so no full raster scan is needed. A behavioural model tracks
// the frame count, the latest requested mode and the expected pixel colour.
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int BAR_H = 16;
  localparam int STEP  = 2;

  localparam logic [11:0] BAR_COLOURS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [11:0] sw = '0;
  logic [1:0]  mode_sel = '0;
  logic        mode_load = 1'b0;
  logic [11:0] rgb;
  logic [1:0]  mode;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_mode = 0;
  int          m_req = 0;
  bit          m_req_valid = 1'b0;
  int          m_frames = 0;
  logic [11:0] m_rgb = '0;
  bit          m_ft = 1'b0;
  logic [11:0] cur_sw = 12'hF0A;

  vga_pattern_gen dut (
    .clk        (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .sw         (sw),
    .mode_sel   (mode_sel),
    .mode_load  (mode_load),
    .rgb        (rgb),
    .mode       (mode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic int model_bar_y();
    return (m_frames * STEP) % V_ACT;
  endfunction

  // Expected colour of an active pixel straight from the pattern rules.
  function automatic logic [11:0] ref_colour(int md, int by, int xx, int yy,
                                             logic [11:0] s);
    logic [11:0] c;
    case (md)
      0: c = s;
      1: c = BAR_COLOURS[xx / (H_ACT / 8)];
      2: c = (((xx / 32) + (yy / 32)) % 2 == 0) ? s : ~s;
      default: c = (yy >= by && yy < by + BAR_H) ? s : 12'h000;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (xx == 0 || xx == H_ACT - 1 || yy == 0 || yy == V_ACT - 1) c = 12'hFFF;
`endif
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] observed,
                             input logic [11:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed,
               expected, $time);
    end
  endtask

  // Drive one clock of inputs, advance the model, and compare all outputs.
  task automatic applyStimulus(input bit pt, input bit vo, input int xx,
                               input int yy, input logic [11:0] s,
                               input int ms, input bit ml);
    bit bnd;
    p_tick    = pt;
    video_on  = vo;
    x         = 10'(xx);
    y         = 10'(yy);
    sw        = s;
    mode_sel  = 2'(ms);
    mode_load = ml;
    @(posedge clk);
    #1;
    bnd = pt && xx == 0 && yy == V_ACT;
    if (pt) m_rgb = vo ? ref_colour(m_mode, model_bar_y(), xx, yy, s) : 12'h000;
    if (ml) begin
      m_req       = ms;
      m_req_valid = 1'b1;
    end
    m_ft = bnd;
    if (bnd) begin
      m_frames++;
      if (m_req_valid) begin
        m_mode      = m_req;
        m_req_valid = 1'b0;
      end
    end
    checkOutput("rgb", rgb, m_rgb);
    checkOutput("mode", {10'b0, mode}, 12'(m_mode));
    checkOutput("frame_tick", {11'b0, frame_tick}, {11'b0, m_ft});
  endtask

  task automatic pixel(input int xx, input int yy);
    applyStimulus(1'b1, (xx < H_ACT && yy < V_ACT), xx, yy, cur_sw, 0, 1'b0);
  endtask

  task automatic frame_edge();
    applyStimulus(1'b1, 1'b0, 0, V_ACT, cur_sw, 0, 1'b0);
  endtask

  task automatic load_mode(input int ms);
    applyStimulus(1'b0, 1'b0, 5, 5, cur_sw, ms, 1'b1);
  endtask

  // Asynchronous reset asserted between clock edges while inputs stay live.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    m_mode = 0; m_req = 0; m_req_valid = 1'b0; m_frames = 0;
    m_rgb = '0; m_ft = 1'b0;
    checkOutput("reset_rgb", rgb, 12'h000);
    checkOutput("reset_mode", {10'b0, mode}, 12'h000);
    checkOutput("reset_ft", {11'b0, frame_tick}, 12'h000);
    @(posedge clk);
    #1;
    checkOutput("reset_hold_rgb", rgb, 12'h000);
    p_tick = 1'b0;
    mode_load = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_rgb", rgb, 12'h000);
  endtask

  initial begin
    int by;
    $display("[TB] start");
    reset = 1'b1;
    #12 reset = 1'b0;
    @(posedge clk);
    #1;

    // Solid colour, then a reset in the middle of active video
    cur_sw = 12'hF0A;
    pixel(100, 100);
    pixel(200, 50);
    p_tick = 1'b1; video_on = 1'b1;
    do_reset();
    pixel(10, 10);
    checkOutput("solid_F0A", rgb, 12'hF0A);
    applyStimulus(1'b1, 1'b0, 700, 10, cur_sw, 0, 1'b0);
    checkOutput("blank_000", rgb, 12'h000);
    applyStimulus(1'b0, 1'b1, 20, 20, cur_sw, 0, 1'b0);
    pixel(300, 200);

    // Mode 1 loaded mid-frame, adopted at the boundary
    load_mode(1);
    pixel(40, 40);
    pixel(41, 40);
    frame_edge();
    checkOutput("mode1_adopt", {10'b0, mode}, 12'h001);
    pixel(0, 100);
    checkOutput("bars_x0", rgb, 12'hFFF);
    pixel(80, 100);
    checkOutput("bars_x80", rgb, 12'hFF0);
    pixel(560, 100);
    checkOutput("bars_x560", rgb, 12'h000);
    for (int i = 0; i < H_ACT; i += 37) pixel(i, 200);

    // Two loads in one frame, then a load coincident with the boundary
    load_mode(2);
    pixel(12, 12);
    load_mode(3);
    frame_edge();
    checkOutput("last_load_wins", {10'b0, mode}, 12'h003);
    pixel(30, 30);
    applyStimulus(1'b1, 1'b0, 0, V_ACT, cur_sw, 2, 1'b1);
    checkOutput("coincident_load", {10'b0, mode}, 12'h002);

    // Checkerboard
    cur_sw = 12'h123;
    pixel(1, 1);
    checkOutput("chk_1_1", rgb, 12'h123);
    pixel(32, 1);
    checkOutput("chk_32_1", rgb, 12'hEDC);
    pixel(32, 32);
    checkOutput("chk_32_32", rgb, 12'h123);
    pixel(0, 0);
    pixel(32, 0);

    // Moving bar from a fresh reset, across the wrap
    do_reset();
    cur_sw = 12'h5A7;
    load_mode(3);
    for (int f = 0; f < 245; f++) begin
      frame_edge();
      by = model_bar_y();
      if (by > 0) pixel($urandom_range(0, H_ACT - 1), by - 1);
      pixel($urandom_range(0, H_ACT - 1), by);
      if (by + BAR_H - 1 < V_ACT) pixel($urandom_range(0, H_ACT - 1), by + BAR_H - 1);
      if (by + BAR_H < V_ACT) pixel($urandom_range(0, H_ACT - 1), by + BAR_H);
      if (by == 470) begin
        pixel(300, 479);
        checkOutput("bar_clip_479", rgb, ref_colour(3, 470, 300, 479, cur_sw));
        pixel(300, 2);
        checkOutput("bar_no_wrap", rgb, 12'h000);
      end
      pixel($urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1));
    end

    // Border pixels in solid mode
    load_mode(0);
    frame_edge();
    cur_sw = 12'h00F;
    pixel(0, 100);
    pixel(639, 5);
    pixel(300, 479);
    pixel(1, 1);
    checkOutput("border_inner", rgb, 12'h00F);

    // Randomized traffic with occasional loads and boundaries
    for (int i = 0; i < 3000; i++) begin
      int r;
      int xx;
      int yy;
      bit ml;
      r  = $urandom_range(0, 99);
      ml = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) cur_sw = 12'($urandom);
      if (r < 3) begin
        xx = 0;
        yy = V_ACT;
      end else begin
        xx = $urandom_range(0, 799);
        yy = $urandom_range(0, 524);
      end
      applyStimulus(($urandom_range(0, 3) != 0) || r < 3,
                    (xx < H_ACT && yy < V_ACT), xx, yy, cur_sw,
                    $urandom_range(0, 3), ml);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
